s100_mem_bridge: RTL and testbench

S100_MEM_BRIDGE -- requirements
Module: s100_mem_bridge

---
 rtl/s100_pkg.sv | 28 ++
 rtl/s100_sync_edge.sv | 29 ++
 rtl/s100_mem_bridge.sv | 138 +++++++++++++
 tb/tb_s100_mem_bridge.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/s100_pkg.sv
// Shared definitions for the S100 memory bridge: FSM state codes, status
// strobe bit positions and the value returned when RAM never answers a read.
package s100_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_RD_REQ  = 3'd1;
  localparam state_t ST_RD_WAIT = 3'd2;
  localparam state_t ST_RD_HOLD = 3'd3;
  localparam state_t ST_WR_REQ  = 3'd4;
  localparam state_t ST_WR_HOLD = 3'd5;

  // Bit positions of the S100 status/strobe lines in the bridge's status vector
  localparam int STAT_SMEMR = 0;
  localparam int STAT_MWRT  = 1;
  localparam int STAT_PDBIN = 2;
  localparam int STAT_W     = 3;

  // Byte presented on DI when the RAM misses its read deadline (undriven bus)
  localparam logic [7:0] FLOAT_BYTE = 8'hFF;

  // Upper-address mask selecting the window base for a power-of-two window
  function automatic logic [15:0] win_mask(input int win_size);
    return ~16'(win_size - 1);
  endfunction

endpackage

// File: rtl/s100_sync_edge.sv
// Two-flop synchronizer for one asynchronous S100 strobe, plus a rising-edge
// flag derived from the synchronized level.
module s100_sync_edge (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise
);

  logic meta_q, sync_q, prev_q;

  // Metastability stage, stable copy, and one-cycle-old copy for edge detect
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= i_async;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign o_sync = sync_q;
  assign o_rise = sync_q & ~prev_q;

endmodule

// File: rtl/s100_mem_bridge.sv
// Bridges S100 memory read/write cycles onto a simple RAM port. Reads stall
// the CPU through PRDY until data (or a timeout float byte) is available;
// writes are posted and never stall the CPU.
module s100_mem_bridge
  import s100_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int          WINDOW_SIZE = 256,
  parameter int          RD_TIMEOUT  = 15
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_bus_addr,
  input  logic [7:0]  i_bus_dout,
  input  logic        i_smemr,
  input  logic        i_mwrt,
  input  logic        i_pdbin,
  output logic [7:0]  o_bus_din,
  output logic        o_bus_din_oe,
  output logic        o_prdy,
  output logic [15:0] o_wr_addr,
  output logic [7:0]  o_wr_data,
  output logic        o_wr_enable,
  output logic [15:0] o_rd_addr,
  output logic        o_rd_enable,
  input  logic [7:0]  i_rd_data,
  input  logic        i_rd_ready,
  input  logic        i_busy
);

  localparam int TMO_W = ($clog2(RD_TIMEOUT + 1) > 4) ? $clog2(RD_TIMEOUT + 1) : 4;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RD_TIMEOUT - 1);

  logic [STAT_W-1:0] stat_async, stat_sync, stat_rise;

  assign stat_async[STAT_SMEMR] = i_smemr;
  assign stat_async[STAT_MWRT]  = i_mwrt;
  assign stat_async[STAT_PDBIN] = i_pdbin;

  for (genvar g = 0; g < STAT_W; g++) begin : g_sync
    s100_sync_edge u_sync (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_async (stat_async[g]),
      .o_sync  (stat_sync[g]),
      .o_rise  (stat_rise[g])
    );
  end

  logic smemr_s, mwrt_s, pdbin_s;
  logic rd_start, wr_start, hit;

  assign smemr_s  = stat_sync[STAT_SMEMR];
  assign mwrt_s   = stat_sync[STAT_MWRT];
  assign pdbin_s  = stat_sync[STAT_PDBIN];
  // (smemr & pdbin) rose iff both are high now and at least one was low last
  // cycle, i.e. one of them just rose while the other is high.
  assign rd_start = (stat_rise[STAT_SMEMR] & pdbin_s) | (stat_rise[STAT_PDBIN] & smemr_s);
  assign wr_start = stat_rise[STAT_MWRT];
  assign hit      = (i_bus_addr & win_mask(WINDOW_SIZE)) == BASE_ADDR;

  state_t           state;
  logic [15:0]      addr_q;
  logic [7:0]       data_q, din_q;
  logic             rd_en_q, wr_en_q;
  logic [TMO_W-1:0] tmo_cnt;

  // Transaction FSM: latch on a hit start, issue one RAM enable when not busy,
  // then hold until the CPU drops its strobe
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      din_q   <= '0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A write edge wins; a coincident read edge is simply dropped
          if (wr_start) begin
            if (hit) begin
              addr_q <= i_bus_addr - BASE_ADDR;
              data_q <= i_bus_dout;
              state  <= ST_WR_REQ;
            end
          end else if (rd_start && hit) begin
            addr_q <= i_bus_addr - BASE_ADDR;
            state  <= ST_RD_REQ;
          end
        end
        ST_RD_REQ: begin
          if (!i_busy) begin
            rd_en_q <= 1'b1;
            tmo_cnt <= '0;
            state   <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (i_rd_ready) begin
            din_q <= i_rd_data;
            state <= ST_RD_HOLD;
          end else if (tmo_cnt == TMO_LAST) begin
            din_q <= FLOAT_BYTE;
            state <= ST_RD_HOLD;
          end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        ST_RD_HOLD: if (!pdbin_s) state <= ST_IDLE;
        ST_WR_REQ: begin
          if (!i_busy) begin
            wr_en_q <= 1'b1;
            state   <= ST_WR_HOLD;
          end
        end
        ST_WR_HOLD: if (!mwrt_s) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // CPU waits only while a read is outstanding; DI is driven only while the
  // CPU is still strobing pdbin in the hold state
  assign o_prdy       = !((state == ST_RD_REQ) || (state == ST_RD_WAIT));
  assign o_bus_din_oe = (state == ST_RD_HOLD) && pdbin_s;
  assign o_bus_din    = din_q;
  assign o_rd_addr    = addr_q;
  assign o_rd_enable  = rd_en_q;
  assign o_wr_addr    = addr_q;
  assign o_wr_data    = data_q;
  assign o_wr_enable  = wr_en_q;

endmodule

// File: tb/tb_s100_mem_bridge.sv
// Directed bench for s100_mem_bridge: default-window instance plus a second
// instance based at 16'h8000 sharing the same bus stimulus.
module tb_s100_mem_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [15:0] bus_addr = '0;
  logic [7:0]  bus_dout = '0;
  logic        smemr = 1'b0, mwrt = 1'b0, pdbin = 1'b0;
  logic [7:0]  rd_data = '0;
  logic        rd_ready = 1'b0, busy = 1'b0;

  logic [7:0]  a_din, h_din;
  logic        a_oe, h_oe, a_prdy, h_prdy;
  logic [15:0] a_wr_addr, h_wr_addr, a_rd_addr, h_rd_addr;
  logic [7:0]  a_wr_data, h_wr_data;
  logic        a_wr_en, h_wr_en, a_rd_en, h_rd_en;

  s100_mem_bridge dut (
    .i_clk(clk), .i_reset(reset), .i_bus_addr(bus_addr), .i_bus_dout(bus_dout),
    .i_smemr(smemr), .i_mwrt(mwrt), .i_pdbin(pdbin),
    .o_bus_din(a_din), .o_bus_din_oe(a_oe), .o_prdy(a_prdy),
    .o_wr_addr(a_wr_addr), .o_wr_data(a_wr_data), .o_wr_enable(a_wr_en),
    .o_rd_addr(a_rd_addr), .o_rd_enable(a_rd_en),
    .i_rd_data(rd_data), .i_rd_ready(rd_ready), .i_busy(busy)
  );

  s100_mem_bridge #(.BASE_ADDR(16'h8000)) dut_hi (
    .i_clk(clk), .i_reset(reset), .i_bus_addr(bus_addr), .i_bus_dout(bus_dout),
    .i_smemr(smemr), .i_mwrt(mwrt), .i_pdbin(pdbin),
    .o_bus_din(h_din), .o_bus_din_oe(h_oe), .o_prdy(h_prdy),
    .o_wr_addr(h_wr_addr), .o_wr_data(h_wr_data), .o_wr_enable(h_wr_en),
    .o_rd_addr(h_rd_addr), .o_rd_enable(h_rd_en),
    .i_rd_data(rd_data), .i_rd_ready(rd_ready), .i_busy(busy)
  );

  int n_cmp = 0, n_bad = 0;
  int a_rd_cnt = 0, a_wr_cnt = 0, h_rd_cnt = 0, h_wr_cnt = 0;

  // Count every enable cycle seen on each RAM port
  always @(posedge clk) begin
    if (a_rd_en) a_rd_cnt <= a_rd_cnt + 1;
    if (a_wr_en) a_wr_cnt <= a_wr_cnt + 1;
    if (h_rd_en) h_rd_cnt <= h_rd_cnt + 1;
    if (h_wr_en) h_wr_cnt <= h_wr_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(3);
    n_cmp++; if (a_prdy !== 1'b1) begin n_bad++; $display("FAIL reset_prdy: got %b want 1", a_prdy); end
    n_cmp++; if (a_oe !== 1'b0) begin n_bad++; $display("FAIL reset_oe: got %b want 0", a_oe); end
    n_cmp++; if (a_din !== 8'h00) begin n_bad++; $display("FAIL reset_din: got %h want 00", a_din); end
    n_cmp++; if ({a_rd_en, a_wr_en} !== 2'b00) begin n_bad++; $display("FAIL reset_en: got %b want 00", {a_rd_en, a_wr_en}); end
    n_cmp++; if (a_rd_addr !== 16'h0) begin n_bad++; $display("FAIL reset_rd_addr: got %h want 0000", a_rd_addr); end
    n_cmp++; if ({a_wr_addr, a_wr_data} !== 24'h0) begin n_bad++; $display("FAIL reset_wr: got %h want 000000", {a_wr_addr, a_wr_data}); end
    n_cmp++; if (h_prdy !== 1'b1) begin n_bad++; $display("FAIL reset_hi_prdy: got %b want 1", h_prdy); end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_read;
    int c0; bit seen;
    c0 = a_rd_cnt; seen = 0;
    bus_addr = 16'h0042; smemr = 1'b1; pdbin = 1'b1;
    for (int i = 0; i < 12 && !seen; i++) begin tick(1); if (a_rd_en) seen = 1; end
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL read_enable: got none want pulse"); end
    n_cmp++; if (a_rd_addr !== 16'h0042) begin n_bad++; $display("FAIL read_addr: got %h want 0042", a_rd_addr); end
    n_cmp++; if (a_prdy !== 1'b0) begin n_bad++; $display("FAIL read_prdy_wait: got %b want 0", a_prdy); end
    tick(3);
    n_cmp++; if (a_prdy !== 1'b0) begin n_bad++; $display("FAIL read_prdy_pre: got %b want 0", a_prdy); end
    rd_ready = 1'b1; rd_data = 8'h5A;
    tick(1);
    rd_ready = 1'b0; rd_data = 8'h00;
    n_cmp++; if ({a_prdy, a_oe} !== 2'b11) begin n_bad++; $display("FAIL read_hold: got prdy,oe=%b want 11", {a_prdy, a_oe}); end
    n_cmp++; if (a_din !== 8'h5A) begin n_bad++; $display("FAIL read_data: got %h want 5a", a_din); end
    tick(2);
    n_cmp++; if ({a_oe, a_din} !== 9'h15A) begin n_bad++; $display("FAIL read_data_held: got %h want 15a", {a_oe, a_din}); end
    pdbin = 1'b0; smemr = 1'b0;
    tick(3);
    n_cmp++; if ({a_prdy, a_oe} !== 2'b10) begin n_bad++; $display("FAIL read_release: got prdy,oe=%b want 10", {a_prdy, a_oe}); end
    n_cmp++; if (a_rd_cnt - c0 !== 1) begin n_bad++; $display("FAIL read_count: got %0d want 1", a_rd_cnt - c0); end
  endtask

  task automatic test_write_busy;
    int w0; bit seen;
    w0 = a_wr_cnt; seen = 0;
    busy = 1'b1; bus_addr = 16'h0010; bus_dout = 8'hA5; mwrt = 1'b1;
    tick(4);
    n_cmp++; if (a_wr_cnt !== w0) begin n_bad++; $display("FAIL write_busy_hold: got %0d enables want 0", a_wr_cnt - w0); end
    busy = 1'b0; bus_addr = 16'h0077; bus_dout = 8'h00;
    for (int i = 0; i < 8 && !seen; i++) begin tick(1); if (a_wr_en) seen = 1; end
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL write_enable: got none want pulse"); end
    n_cmp++; if (a_wr_addr !== 16'h0010) begin n_bad++; $display("FAIL write_addr: got %h want 0010", a_wr_addr); end
    n_cmp++; if (a_wr_data !== 8'hA5) begin n_bad++; $display("FAIL write_data: got %h want a5", a_wr_data); end
    n_cmp++; if (a_prdy !== 1'b1) begin n_bad++; $display("FAIL write_prdy: got %b want 1", a_prdy); end
    tick(4);
    mwrt = 1'b0;
    tick(4);
    n_cmp++; if (a_wr_cnt - w0 !== 1) begin n_bad++; $display("FAIL write_count: got %0d want 1", a_wr_cnt - w0); end
  endtask

  task automatic test_simultaneous;
    int r0, w0; bit seen;
    r0 = a_rd_cnt; w0 = a_wr_cnt; seen = 0;
    bus_addr = 16'h0020; bus_dout = 8'h3C;
    mwrt = 1'b1; smemr = 1'b1; pdbin = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin tick(1); if (a_wr_en) seen = 1; end
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL simul_write: got none want pulse"); end
    n_cmp++; if ({a_wr_addr, a_wr_data} !== 24'h00203C) begin n_bad++; $display("FAIL simul_wr_bus: got %h want 00203c", {a_wr_addr, a_wr_data}); end
    n_cmp++; if (a_prdy !== 1'b1) begin n_bad++; $display("FAIL simul_prdy: got %b want 1", a_prdy); end
    tick(3);
    mwrt = 1'b0; smemr = 1'b0; pdbin = 1'b0;
    tick(6);
    n_cmp++; if (a_rd_cnt !== r0) begin n_bad++; $display("FAIL simul_no_read: got %0d reads want 0", a_rd_cnt - r0); end
    n_cmp++; if (a_wr_cnt - w0 !== 1) begin n_bad++; $display("FAIL simul_write_count: got %0d want 1", a_wr_cnt - w0); end
  endtask

  task automatic test_timeout;
    bit seen; int k;
    seen = 0; k = 0;
    bus_addr = 16'h0050; smemr = 1'b1; pdbin = 1'b1;
    for (int i = 0; i < 12 && !seen; i++) begin tick(1); if (a_rd_en) seen = 1; end
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL tmo_enable: got none want pulse"); end
    for (int i = 1; i <= 40 && k == 0; i++) begin tick(1); if (a_prdy) k = i; end
    n_cmp++; if (k != 15) begin n_bad++; $display("FAIL tmo_cycles: got %0d want 15", k); end
    n_cmp++; if ({a_oe, a_din} !== 9'h1FF) begin n_bad++; $display("FAIL tmo_float: got oe,din=%h want 1ff", {a_oe, a_din}); end
    smemr = 1'b0; pdbin = 1'b0;
    tick(4);
    n_cmp++; if (a_oe !== 1'b0) begin n_bad++; $display("FAIL tmo_release: got %b want 0", a_oe); end
  endtask

  task automatic test_miss;
    int hr0, aw0; bit bad_idle, seen;
    hr0 = h_rd_cnt; bad_idle = 0; seen = 0;
    bus_addr = 16'h0042; smemr = 1'b1; pdbin = 1'b1;
    for (int i = 0; i < 12; i++) begin tick(1); if (!h_prdy || h_oe) bad_idle = 1; end
    n_cmp++; if (bad_idle !== 1'b0) begin n_bad++; $display("FAIL miss_idle: got prdy/oe disturbed want idle"); end
    n_cmp++; if (h_rd_cnt !== hr0) begin n_bad++; $display("FAIL miss_no_read: got %0d reads want 0", h_rd_cnt - hr0); end
    smemr = 1'b0; pdbin = 1'b0;
    tick(30);
    n_cmp++; if (a_prdy !== 1'b1) begin n_bad++; $display("FAIL miss_drain: got %b want 1", a_prdy); end
    aw0 = a_wr_cnt;
    bus_addr = 16'h8010; bus_dout = 8'h99; mwrt = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin tick(1); if (h_wr_en) seen = 1; end
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL hi_write: got none want pulse"); end
    n_cmp++; if ({h_wr_addr, h_wr_data} !== 24'h001099) begin n_bad++; $display("FAIL hi_write_bus: got %h want 001099", {h_wr_addr, h_wr_data}); end
    mwrt = 1'b0;
    tick(5);
    n_cmp++; if (a_wr_cnt !== aw0) begin n_bad++; $display("FAIL lo_write_miss: got %0d writes want 0", a_wr_cnt - aw0); end
  endtask

  task automatic test_early_release;
    int r0; bit seen;
    r0 = a_rd_cnt; seen = 0;
    busy = 1'b1; bus_addr = 16'h0060; smemr = 1'b1; pdbin = 1'b1;
    tick(4);
    smemr = 1'b0; pdbin = 1'b0;
    tick(4);
    n_cmp++; if (a_prdy !== 1'b0) begin n_bad++; $display("FAIL early_prdy: got %b want 0", a_prdy); end
    busy = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin tick(1); if (a_rd_en) seen = 1; end
    n_cmp++; if (seen !== 1'b1 || a_rd_addr !== 16'h0060) begin n_bad++; $display("FAIL early_enable: got seen=%b addr=%h want 1 0060", seen, a_rd_addr); end
    tick(2);
    rd_ready = 1'b1; rd_data = 8'h77;
    tick(1);
    rd_ready = 1'b0;
    n_cmp++; if ({a_prdy, a_oe} !== 2'b10) begin n_bad++; $display("FAIL early_no_drive: got prdy,oe=%b want 10", {a_prdy, a_oe}); end
    tick(3);
    n_cmp++; if (a_rd_cnt - r0 !== 1 || a_oe !== 1'b0) begin n_bad++; $display("FAIL early_once: got reads=%0d oe=%b want 1 0", a_rd_cnt - r0, a_oe); end
  endtask

  task automatic test_reset_mid;
    int r0; bit seen;
    seen = 0;
    bus_addr = 16'h0030; smemr = 1'b1; pdbin = 1'b1;
    for (int i = 0; i < 12 && !seen; i++) begin tick(1); if (a_rd_en) seen = 1; end
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rstmid_enable: got none want pulse"); end
    tick(2);
    reset = 1'b1; smemr = 1'b0; pdbin = 1'b0;
    tick(1);
    n_cmp++; if ({a_prdy, a_oe, a_rd_en} !== 3'b100) begin n_bad++; $display("FAIL rstmid_outputs: got prdy,oe,en=%b want 100", {a_prdy, a_oe, a_rd_en}); end
    r0 = a_rd_cnt;
    tick(2);
    reset = 1'b0; rd_ready = 1'b1; rd_data = 8'h11;
    tick(1);
    rd_ready = 1'b0;
    tick(12);
    n_cmp++; if (a_rd_cnt !== r0) begin n_bad++; $display("FAIL rstmid_late_enable: got %0d want 0", a_rd_cnt - r0); end
    n_cmp++; if ({a_prdy, a_oe, a_din} !== 10'h200) begin n_bad++; $display("FAIL rstmid_idle: got %h want 200", {a_prdy, a_oe, a_din}); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_busy();
    test_simultaneous();
    test_timeout();
    test_miss();
    test_early_release();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
